burst_job_scheduler: RTL and testbench
======================================

Name: burst_job_scheduler

Overview:
Descriptor-queue controller that sequences the burst-copy/scale datapath (burst_master_4) through that block's 8-register CSR slave. Host software pushes copy jobs (src, dst, len, bursts, coeff) into an internal queue. The scheduler programs each job, starts it, polls done, clears done, and moves to the next job with no CPU involvement. It sits between the host CSR bus and the datapath's avs_* port.

Parameters:
QUEUE_DEPTH, 4, descriptor queue entries (power of 2, ≥2)
POLL_GAP, 8, idle cycles between done polls (0 = poll every cycle)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
avs_write  in  1  host CSR write strobe
avs_read  in  1  host CSR read strobe
avs_address  in  3  host CSR word address
avs_writedata  in  32  host write data
avs_readdata  out  32  host read data, combinational on avs_address
cm_write  out  1  datapath CSR write strobe
cm_read  out  1  datapath CSR read strobe
cm_address  out  3  datapath CSR address
cm_writedata  out  32  datapath CSR write data
cm_readdata  in  32  datapath CSR read data, valid same cycle as cm_read
irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high. Reset clears all registers, empties the queue and zeroes all outputs. Staged coeff resets to 1; staged bursts reset to 256/256.
- Reset mid-job: the datapath is not reset by this block. System reset is shared.
- Host map, write side:
  - 0 CTRL: [0] enable, [1] irq_en, [2] flush (self-clearing).
  - 1 STATUS: write 1 to [4] clears done_irq; write 1 to [5] clears overflow.
  - 2 SRC, 3 DST, 4 LEN, 6 COEFF: staging registers.
  - 5 BURSTS: [8:0] rd_burst, [24:16] wr_burst.
  - 7 PUSH: any write enqueues {SRC, DST, LEN, BURSTS, COEFF}.
- Host map, read side:
  - 1 STATUS: [0] busy, [1] q_empty, [2] q_full, [4] done_irq, [5] overflow, [15:8] q_count.
  - 7: jobs_done count, 32-bit, wraps.
  - Others return their stored value.
- Push when full: descriptor is dropped and overflow is set.
- Push and pop in the same cycle are both honoured.
- Flush empties the queue only. An in-flight job completes normally.
- FSM states: IDLE, PROG, START, POLL, WAIT, CLEAR.
- IDLE: if enable and queue not empty, pop the head into the job register, set step=0, go to PROG.
- PROG: one cm_write per cycle, 6 cycles, in the fixed order addr 5 (rd_burst), 6 (wr_burst), 2 (src), 3 (dst), 7 (coeff), 4 (len).
  - rd_burst must be written before len, because the datapath rounds len using rd_burst.
  - cm_writedata for burst words is zero-extended from 9 bits.
- START: cm_write addr 0 data 1, one cycle; then go to POLL.
- POLL: cm_read addr 1 for one cycle and sample cm_readdata[0].
  - If 1, go to CLEAR.
  - Else go to WAIT, which counts POLL_GAP cycles and then returns to POLL. POLL_GAP=0 skips WAIT.
- CLEAR: cm_write addr 1 data 1, one cycle. Then jobs_done++ and done_irq←1; if the queue is empty or enable=0, done_irq is also set. Go to IDLE.
- First program write of the next job can occur 2 cycles after CLEAR, via IDLE pop.
- cm_write and cm_read are never asserted together. cm_* are registered outputs; all are 0 when not driving.
- busy = state≠IDLE.
- irq = irq_en & done_irq.
- A host clear of done_irq in the same cycle as a CLEAR set: the set wins.
- Clearing enable mid-job finishes the current job, then holds in IDLE.
- LEN is passed unmodified; LEN=0 is legal (the datapath signals done immediately).
- Descriptor queue: circular buffer, pointers one bit wider than the index, full/empty from pointer compare. Count is in the range 0..QUEUE_DEPTH.

Decomposition:
- Shared package: datapath CSR address constants (CTRL=0, DONE=1, SRC=2, DST=3, LEN=4, RDB=5, WRB=6, COEFF=7), host register offsets, descriptor struct/width (146 bits), FSM state encoding.
- One sub-module: sched_desc_queue, a parameterised sync FIFO with push/pop/count/flush and registered output.

Test Plan:
- Single job (SRC=0x1000, DST=0x8000, LEN=0x400, rd/wr=64, COEFF=3), enable=1, model asserts done 40 cycles after start:
  - exactly writes 5:64, 6:64, 2:0x1000, 3:0x8000, 7:3, 4:0x400, 0:1 on consecutive cycles;
  - then polls at POLL_GAP+1 spacing, then writes 1:1;
  - jobs_done=1; irq=1 when irq_en=1.
- Push 4 jobs with enable=0:
  - q_full=1, count=4;
  - fifth push sets overflow and is dropped;
  - enable → 4 jobs run in FIFO order, jobs_done=4, q_empty=1.
- Push 3 jobs, enable, flush during the first job's POLL: first job completes, jobs_done=1, remaining two are never programmed.
- POLL_GAP=0 with done pre-asserted: POLL→CLEAR in 1 cycle; cm_read is never asserted together with cm_write.
- Reset asserted during PROG step 3: next cycle all cm_* =0, queue empty, jobs_done=0, irq=0, COEFF readback=1.
- Host clears done_irq in the same cycle as CLEAR sets it: done_irq reads 1.

Source files
------------

// File: rtl/burst_job_scheduler_pkg.sv
// Shared definitions for the burst job scheduler.
//   - Datapath (burst_master_4) CSR word addresses driven on cm_address.
//   - Host register offsets decoded from avs_address.
//   - Descriptor layout held in the queue (146 bits).
//   - FSM state encoding and the program-sequence helper.
package burst_job_scheduler_pkg;

    // Datapath CSR map
    localparam logic [2:0] CM_CTRL  = 3'd0;
    localparam logic [2:0] CM_DONE  = 3'd1;
    localparam logic [2:0] CM_SRC   = 3'd2;
    localparam logic [2:0] CM_DST   = 3'd3;
    localparam logic [2:0] CM_LEN   = 3'd4;
    localparam logic [2:0] CM_RDB   = 3'd5;
    localparam logic [2:0] CM_WRB   = 3'd6;
    localparam logic [2:0] CM_COEFF = 3'd7;

    // Host register map
    localparam logic [2:0] HOST_CTRL   = 3'd0;
    localparam logic [2:0] HOST_STATUS = 3'd1;
    localparam logic [2:0] HOST_SRC    = 3'd2;
    localparam logic [2:0] HOST_DST    = 3'd3;
    localparam logic [2:0] HOST_LEN    = 3'd4;
    localparam logic [2:0] HOST_BURSTS = 3'd5;
    localparam logic [2:0] HOST_COEFF  = 3'd6;
    localparam logic [2:0] HOST_PUSH   = 3'd7;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [8:0]  rd_burst;
        logic [8:0]  wr_burst;
        logic [31:0] coeff;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_START,
        ST_POLL,
        ST_WAIT,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } cm_word_t;

    // Programming order: rd_burst must land before len because the
    // datapath rounds len using the read burst size.
    function automatic cm_word_t prog_word(input desc_t d, input logic [2:0] step);
        cm_word_t w;
        case (step)
            3'd0:    begin w.addr = CM_RDB;   w.data = {23'd0, d.rd_burst}; end
            3'd1:    begin w.addr = CM_WRB;   w.data = {23'd0, d.wr_burst}; end
            3'd2:    begin w.addr = CM_SRC;   w.data = d.src;               end
            3'd3:    begin w.addr = CM_DST;   w.data = d.dst;               end
            3'd4:    begin w.addr = CM_COEFF; w.data = d.coeff;             end
            default: begin w.addr = CM_LEN;   w.data = d.len;               end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/burst_job_scheduler_desc_queue.sv
// sched_desc_queue: synchronous circular-buffer FIFO with a registered
// head word.
//   push/din   enqueue (accepted when not full, or when popping the same cycle)
//   pop        dequeue; dout always holds the current head when not empty
//   flush      empties the queue (pointers reset), storage untouched
//   count      occupancy 0..DEPTH; empty/full from pointer compare
//   drop       pulses when a push is refused because the queue is full
module sched_desc_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 146
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] dout_reg;
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign drop        = push && !push_ok;
    assign rd_ptr_next = rd_ptr_reg + PTR_ONE;
    assign dout        = dout_reg;

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // The head register tracks mem[rd_ptr]; when the queue drains to its
    // last entry while a push arrives, the new word bypasses storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_next;
                if (count == PTR_ONE) begin
                    if (push_ok) begin
                        dout_reg <= din;
                    end
                end else begin
                    dout_reg <= mem_reg[rd_ptr_next[AW-1:0]];
                end
            end else if (empty && push_ok) begin
                dout_reg <= din;
            end
        end
    end

endmodule

// File: rtl/burst_job_scheduler.sv
// burst_job_scheduler: descriptor-queue controller that programs, starts,
// polls and acknowledges jobs on the burst-copy datapath CSR slave.
//   clk, reset            system clock, synchronous active-high reset
//   avs_*                 host CSR slave (readdata combinational on address)
//   cm_*                  registered CSR master towards the datapath
//   irq                   level interrupt = irq_en & done_irq
module burst_job_scheduler
    import burst_job_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int POLL_GAP    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [2:0]  avs_address,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        cm_write,
    output logic        cm_read,
    output logic [2:0]  cm_address,
    output logic [31:0] cm_writedata,
    input  logic [31:0] cm_readdata,
    output logic        irq
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    // Host staging and control
    logic [31:0] src_reg, dst_reg, len_reg, coeff_reg;
    logic [8:0]  rd_burst_reg, wr_burst_reg;
    logic        enable_reg, irq_en_reg, overflow_reg;

    // Sequencer
    state_t      state_reg;
    logic [2:0]  step_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    desc_t       job_reg;
    logic [31:0] jobs_done_reg;
    logic        done_irq_reg;
    logic        cm_write_reg, cm_read_reg;
    logic [2:0]  cm_address_reg;
    logic [31:0] cm_writedata_reg;

    // Queue interface
    desc_t            staged_desc, q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_empty, q_full, q_drop;
    logic             push_req, pop, flush;
    logic             host_wr_status, busy;
    cm_word_t         prog_first, prog_next;
    logic             unused_inputs;

    assign unused_inputs  = ^{avs_read, cm_readdata[31:1]};
    assign host_wr_status = avs_write && (avs_address == HOST_STATUS);
    assign push_req       = avs_write && (avs_address == HOST_PUSH);
    assign flush          = avs_write && (avs_address == HOST_CTRL) && avs_writedata[2];
    assign pop            = (state_reg == ST_IDLE) && enable_reg && !q_empty;
    assign busy           = (state_reg != ST_IDLE);
    assign staged_desc    = {src_reg, dst_reg, len_reg, rd_burst_reg, wr_burst_reg, coeff_reg};
    assign prog_first     = prog_word(q_head, 3'd0);
    assign prog_next      = prog_word(job_reg, step_reg + 3'd1);

    sched_desc_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (DESC_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .flush (flush),
        .din   (staged_desc),
        .dout  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full),
        .drop  (q_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            src_reg      <= '0;
            dst_reg      <= '0;
            len_reg      <= '0;
            coeff_reg    <= 32'd1;
            rd_burst_reg <= 9'd256;
            wr_burst_reg <= 9'd256;
            enable_reg   <= 1'b0;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    HOST_CTRL:   begin
                        enable_reg <= avs_writedata[0];
                        irq_en_reg <= avs_writedata[1];
                    end
                    HOST_SRC:    src_reg   <= avs_writedata;
                    HOST_DST:    dst_reg   <= avs_writedata;
                    HOST_LEN:    len_reg   <= avs_writedata;
                    HOST_COEFF:  coeff_reg <= avs_writedata;
                    HOST_BURSTS: begin
                        rd_burst_reg <= avs_writedata[8:0];
                        wr_burst_reg <= avs_writedata[24:16];
                    end
                    default: ;
                endcase
            end
            if (q_drop) begin
                overflow_reg <= 1'b1;
            end else if (host_wr_status && avs_writedata[5]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Sequencer with registered cm_* outputs: each transition loads the
    // bus word that the next state presents for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            step_reg         <= '0;
            gap_cnt_reg      <= '0;
            job_reg          <= '0;
            jobs_done_reg    <= '0;
            done_irq_reg     <= 1'b0;
            cm_write_reg     <= 1'b0;
            cm_read_reg      <= 1'b0;
            cm_address_reg   <= '0;
            cm_writedata_reg <= '0;
        end else begin
            cm_write_reg     <= 1'b0;
            cm_read_reg      <= 1'b0;
            cm_address_reg   <= '0;
            cm_writedata_reg <= '0;
            // Host clear first so a same-cycle completion set overrides it.
            if (host_wr_status && avs_writedata[4]) begin
                done_irq_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        job_reg          <= q_head;
                        step_reg         <= '0;
                        state_reg        <= ST_PROG;
                        cm_write_reg     <= 1'b1;
                        cm_address_reg   <= prog_first.addr;
                        cm_writedata_reg <= prog_first.data;
                    end
                end
                ST_PROG: begin
                    cm_write_reg <= 1'b1;
                    if (step_reg == 3'd5) begin
                        state_reg        <= ST_START;
                        cm_address_reg   <= CM_CTRL;
                        cm_writedata_reg <= 32'd1;
                    end else begin
                        step_reg         <= step_reg + 3'd1;
                        cm_address_reg   <= prog_next.addr;
                        cm_writedata_reg <= prog_next.data;
                    end
                end
                ST_START: begin
                    state_reg      <= ST_POLL;
                    cm_read_reg    <= 1'b1;
                    cm_address_reg <= CM_DONE;
                end
                ST_POLL: begin
                    if (cm_readdata[0]) begin
                        state_reg        <= ST_CLEAR;
                        cm_write_reg     <= 1'b1;
                        cm_address_reg   <= CM_DONE;
                        cm_writedata_reg <= 32'd1;
                    end else if (POLL_GAP == 0) begin
                        cm_read_reg    <= 1'b1;
                        cm_address_reg <= CM_DONE;
                    end else begin
                        state_reg   <= ST_WAIT;
                        gap_cnt_reg <= GAP_W'(POLL_GAP - 1);
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg      <= ST_POLL;
                        cm_read_reg    <= 1'b1;
                        cm_address_reg <= CM_DONE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                ST_CLEAR: begin
                    jobs_done_reg <= jobs_done_reg + 32'd1;
                    done_irq_reg  <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            HOST_CTRL:   avs_readdata = {30'd0, irq_en_reg, enable_reg};
            HOST_STATUS: avs_readdata = {16'd0, 8'(q_count), 2'b00, overflow_reg,
                                         done_irq_reg, 1'b0, q_full, q_empty, busy};
            HOST_SRC:    avs_readdata = src_reg;
            HOST_DST:    avs_readdata = dst_reg;
            HOST_LEN:    avs_readdata = len_reg;
            HOST_BURSTS: avs_readdata = {7'd0, wr_burst_reg, 7'd0, rd_burst_reg};
            HOST_COEFF:  avs_readdata = coeff_reg;
            default:     avs_readdata = jobs_done_reg;
        endcase
    end

    assign cm_write     = cm_write_reg;
    assign cm_read      = cm_read_reg;
    assign cm_address   = cm_address_reg;
    assign cm_writedata = cm_writedata_reg;
    assign irq          = irq_en_reg & done_irq_reg;

endmodule

// File: tb/tb_burst_job_scheduler.sv
// Self-checking bench for burst_job_scheduler: a register table plus
// directed multi-cycle sequences against a small datapath model.
module tb_burst_job_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance (POLL_GAP = 8)
    logic        avs_write = 1'b0, avs_read = 1'b0;
    logic [2:0]  avs_address = '0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        cm_write, cm_read, irq;
    logic [2:0]  cm_address;
    logic [31:0] cm_writedata, cm_readdata;

    // Second instance (POLL_GAP = 0)
    logic        h0_write = 1'b0, h0_read = 1'b0;
    logic [2:0]  h0_address = '0;
    logic [31:0] h0_writedata = '0;
    logic [31:0] h0_readdata;
    logic        cm0_write, cm0_read, irq0;
    logic [2:0]  cm0_address;
    logic [31:0] cm0_writedata, cm0_readdata;

    burst_job_scheduler #(.QUEUE_DEPTH(4), .POLL_GAP(8)) u_dut (
        .clk(clk), .reset(reset),
        .avs_write(avs_write), .avs_read(avs_read), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .cm_write(cm_write), .cm_read(cm_read), .cm_address(cm_address),
        .cm_writedata(cm_writedata), .cm_readdata(cm_readdata), .irq(irq)
    );

    burst_job_scheduler #(.QUEUE_DEPTH(4), .POLL_GAP(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .avs_write(h0_write), .avs_read(h0_read), .avs_address(h0_address),
        .avs_writedata(h0_writedata), .avs_readdata(h0_readdata),
        .cm_write(cm0_write), .cm_read(cm0_read), .cm_address(cm0_address),
        .cm_writedata(cm0_writedata), .cm_readdata(cm0_readdata), .irq(irq0)
    );

    // Datapath model: done rises 40 cycles after a start write, cleared by 1:1.
    typedef struct { logic [2:0] addr; logic [31:0] data; int cyc; } txn_t;
    txn_t wlog[$], wlog0[$];
    int   plog[$], plog0[$];
    int   cyc = 0, dp_cnt = 0, collide = 0;
    logic dp_done = 1'b0;

    assign cm_readdata  = {31'd0, dp_done};
    assign cm0_readdata = 32'd1;   // done already asserted

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            dp_done <= 1'b0;
            dp_cnt  <= 0;
            wlog.delete();  plog.delete();
            wlog0.delete(); plog0.delete();
        end else begin
            if ((cm_write && cm_read) || (cm0_write && cm0_read)) collide <= collide + 1;
            if (dp_cnt == 1) dp_done <= 1'b1;
            if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
            if (cm_write) begin
                wlog.push_back('{addr: cm_address, data: cm_writedata, cyc: cyc});
                if (cm_address == 3'd0 && cm_writedata[0]) dp_cnt <= 40;
                if (cm_address == 3'd1 && cm_writedata[0]) dp_done <= 1'b0;
            end
            if (cm_read) plog.push_back(cyc);
            if (cm0_write) wlog0.push_back('{addr: cm0_address, data: cm0_writedata, cyc: cyc});
            if (cm0_read) plog0.push_back(cyc);
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic host_write(input bit sel, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin h0_write = 1'b1; h0_address = a; h0_writedata = d; end
        else begin avs_write = 1'b1; avs_address = a; avs_writedata = d; end
        @(negedge clk);
        avs_write = 1'b0;
        h0_write  = 1'b0;
    endtask

    task automatic host_read(input bit sel, input logic [2:0] a, output logic [31:0] d);
        if (sel) begin h0_read = 1'b1; h0_address = a; #1; d = h0_readdata; h0_read = 1'b0; end
        else begin avs_read = 1'b1; avs_address = a; #1; d = avs_readdata; avs_read = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_jobs(input bit sel, input int target, input int budget, input string name);
        logic [31:0] d;
        int n = 0;
        host_read(sel, 3'd7, d);
        while (d != 32'(target) && n < budget) begin
            @(negedge clk);
            host_read(sel, 3'd7, d);
            n++;
        end
        check(name, d, 32'(target));
    endtask

    // Returns at the negedge inside the cycle where the awaited bus word is driven.
    task automatic wait_cm(input bit want_read, input logic [2:0] a, input int budget, input string name);
        int  n = 0;
        bit  found;
        @(negedge clk);
        found = want_read ? cm_read : (cm_write && cm_address == a);
        while (!found && n < budget) begin
            @(negedge clk);
            found = want_read ? cm_read : (cm_write && cm_address == a);
            n++;
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    typedef struct { bit wr; logic [2:0] addr; logic [31:0] data; logic [31:0] exp; string name; } vec_t;
    vec_t vecs[12];

    logic [2:0]  exp_a [8] = '{3'd5, 3'd6, 3'd2, 3'd3, 3'd7, 3'd4, 3'd0, 3'd1};
    logic [31:0] exp_d [8] = '{32'd64, 32'd64, 32'h1000, 32'h8000, 32'd3, 32'h400, 32'd1, 32'd1};

    initial begin
        logic [31:0] rd;
        int srcs[$];

        vecs[0]  = '{0, 3'd0, 32'h0,        32'h0,        "rst_ctrl"};
        vecs[1]  = '{0, 3'd1, 32'h0,        32'h2,        "rst_status"};
        vecs[2]  = '{0, 3'd2, 32'h0,        32'h0,        "rst_src"};
        vecs[3]  = '{0, 3'd5, 32'h0,        32'h01000100, "rst_bursts"};
        vecs[4]  = '{0, 3'd6, 32'h0,        32'h1,        "rst_coeff"};
        vecs[5]  = '{0, 3'd7, 32'h0,        32'h0,        "rst_jobs_done"};
        vecs[6]  = '{1, 3'd2, 32'h12345678, 32'h12345678, "src_rw"};
        vecs[7]  = '{1, 3'd5, 32'hFFFFFFFF, 32'h01FF01FF, "bursts_mask"};
        vecs[8]  = '{1, 3'd6, 32'h0,        32'h0,        "coeff_rw"};
        vecs[9]  = '{1, 3'd0, 32'h2,        32'h2,        "ctrl_irq_en"};
        vecs[10] = '{1, 3'd0, 32'h6,        32'h2,        "ctrl_flush_selfclr"};
        vecs[11] = '{1, 3'd4, 32'hABCD0000, 32'hABCD0000, "len_rw"};

        do_reset();
        check("rst_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) host_write(0, vecs[i].addr, vecs[i].data);
            host_read(0, vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // POLL_GAP=0, done pre-asserted, default staging (LEN=0, bursts 256, coeff 1)
        host_write(1, 3'd7, 32'd0);
        host_write(1, 3'd0, 32'd1);
        wait_jobs(1, 1, 200, "g0_jobs_done");
        check("g0_wlog_size", wlog0.size(), 32'd8);
        check("g0_poll_count", plog0.size(), 32'd1);
        if (wlog0.size() == 8 && plog0.size() == 1) begin
            check("g0_rdb_zext", wlog0[0].data, 32'd256);
            check("g0_coeff", wlog0[4].data, 32'd1);
            check("g0_len0", {wlog0[5].addr, wlog0[5].data[28:0]}, 32'h80000000);
            check("g0_poll_after_start", plog0[0], wlog0[6].cyc + 1);
            check("g0_clear_after_poll", wlog0[7].cyc, plog0[0] + 1);
            check("g0_clear_word", {wlog0[7].addr, wlog0[7].data[28:0]}, 32'h20000001);
        end

        // Single job
        host_write(0, 3'd2, 32'h1000);
        host_write(0, 3'd3, 32'h8000);
        host_write(0, 3'd4, 32'h400);
        host_write(0, 3'd5, 32'h00400040);
        host_write(0, 3'd6, 32'd3);
        host_write(0, 3'd7, 32'd0);
        host_write(0, 3'd0, 32'h3);
        wait_jobs(0, 1, 400, "j1_jobs_done");
        check("j1_wlog_size", wlog.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) begin
                check($sformatf("j1_w%0d_addr", i), {29'd0, wlog[i].addr}, {29'd0, exp_a[i]});
                check($sformatf("j1_w%0d_data", i), wlog[i].data, exp_d[i]);
                if (i < 7) check($sformatf("j1_w%0d_cycle", i), wlog[i].cyc, wlog[0].cyc + i);
            end
        end
        check("j1_poll_count", plog.size(), 32'd6);
        for (int i = 1; i < plog.size(); i++)
            check($sformatf("j1_poll_gap%0d", i), plog[i] - plog[i-1], 32'd9);
        if (wlog.size() == 8 && plog.size() > 0) begin
            check("j1_first_poll", plog[0], wlog[6].cyc + 1);
            check("j1_clear_cycle", wlog[7].cyc, plog[plog.size()-1] + 1);
        end
        check("j1_irq", {31'd0, irq}, 32'd1);

        // Four jobs queued with enable=0, fifth overflows
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            host_write(0, 3'd2, 32'(i * 32'h100));
            host_write(0, 3'd7, 32'd0);
        end
        host_read(0, 3'd1, rd);
        check("q4_status_full", rd, 32'h0404);
        host_write(0, 3'd2, 32'hDEAD);
        host_write(0, 3'd7, 32'd0);
        host_read(0, 3'd1, rd);
        check("q4_overflow", rd, 32'h0424);
        host_write(0, 3'd0, 32'h1);
        wait_jobs(0, 4, 1500, "q4_jobs_done");
        foreach (wlog[i]) if (wlog[i].addr == 3'd2) srcs.push_back(int'(wlog[i].data));
        check("q4_src_writes", srcs.size(), 32'd4);
        for (int i = 0; i < srcs.size() && i < 4; i++)
            check($sformatf("q4_order%0d", i), srcs[i], 32'((i + 1) * 32'h100));
        host_read(0, 3'd1, rd);
        check("q4_status_end", rd, 32'h0032);
        check("q4_irq_masked", {31'd0, irq}, 32'd0);
        host_write(0, 3'd1, 32'h30);
        host_read(0, 3'd1, rd);
        check("q4_status_cleared", rd, 32'h0002);

        // Flush during first job's polling
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            host_write(0, 3'd2, 32'(32'hA0 + i));
            host_write(0, 3'd7, 32'd0);
        end
        host_write(0, 3'd0, 32'h1);
        wait_cm(1, 3'd1, 100, "fl_reach_poll");
        host_write(0, 3'd0, 32'h5);
        wait_jobs(0, 1, 400, "fl_jobs_done");
        repeat (150) @(negedge clk);
        host_read(0, 3'd7, rd);
        check("fl_jobs_still1", rd, 32'd1);
        srcs.delete();
        foreach (wlog[i]) if (wlog[i].addr == 3'd2) srcs.push_back(int'(wlog[i].data));
        check("fl_src_writes", srcs.size(), 32'd1);
        host_read(0, 3'd1, rd);
        check("fl_status", rd, 32'h0012);

        // Reset during PROG step 3 (DST write on the bus)
        do_reset();
        host_write(0, 3'd6, 32'd9);
        host_write(0, 3'd7, 32'd0);
        host_write(0, 3'd0, 32'h3);
        wait_cm(0, 3'd3, 50, "rp_reach_step3");
        reset = 1'b1;
        @(negedge clk);
        check("rp_cm_strobes", {30'd0, cm_write, cm_read}, 32'd0);
        check("rp_cm_addr", {29'd0, cm_address}, 32'd0);
        check("rp_cm_data", cm_writedata, 32'd0);
        check("rp_irq", {31'd0, irq}, 32'd0);
        host_read(0, 3'd1, rd);
        check("rp_status", rd, 32'h0002);
        host_read(0, 3'd7, rd);
        check("rp_jobs_done", rd, 32'd0);
        host_read(0, 3'd6, rd);
        check("rp_coeff", rd, 32'd1);
        reset = 1'b0;

        // Host clear of done_irq in the CLEAR cycle loses to the set
        host_write(0, 3'd7, 32'd0);
        host_write(0, 3'd0, 32'h3);
        wait_cm(0, 3'd1, 300, "dc_reach_clear");
        avs_write = 1'b1; avs_address = 3'd1; avs_writedata = 32'h10;
        @(negedge clk);
        avs_write = 1'b0;
        host_read(0, 3'd1, rd);
        check("dc_done_irq_set_wins", {31'd0, rd[4]}, 32'd1);
        check("dc_irq", {31'd0, irq}, 32'd1);
        host_write(0, 3'd1, 32'h10);
        host_read(0, 3'd1, rd);
        check("dc_done_irq_cleared", {31'd0, rd[4]}, 32'd0);
        check("dc_irq_low", {31'd0, irq}, 32'd0);

        check("no_read_write_overlap", collide, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
